// File: rtl/alu_sequencer.sv
// Micro-sequencer that steps a small stored program through the 8-bit ALU core,
// presenting selector/immediate pairs and capturing each result with a start/busy/done handshake.
module alu_sequencer #(
    parameter int          ADDR_W        = 4,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [3:0]  IDLE_SEL      = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [11:0]              prog_wdata,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        last_addr,
    input  logic                     abort,
    output logic [3:0]               alu_sel,
    output logic signed [7:0]        alu_data,
    input  logic signed [7:0]        alu_y,
    output logic                     busy,
    output logic                     done,
    output logic                     step_valid,
    output logic signed [7:0]        step_result,
    output logic                     prog_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_last;
    logic [CNT_W-1:0]    r_settle;
    logic [11:0]         r_mem [DEPTH];

    logic                w_running;
    logic                w_wr_ok;
    logic [11:0]         w_instr;

    assign w_running = (r_state == S_ISSUE) || (r_state == S_CAPTURE) || (r_state == S_GAP);
    assign w_wr_ok   = prog_we && !w_running;
    assign w_instr   = r_mem[r_pc];

    // Program memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_last      <= '0;
            r_settle    <= '0;
            alu_sel     <= IDLE_SEL;
            alu_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_valid  <= 1'b0;
            step_result <= '0;
            prog_err    <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            done       <= 1'b0;
            if (prog_we && w_running)
                prog_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_last   <= last_addr;
                        r_pc     <= '0;
                        r_settle <= SETTLE_INIT;
                        prog_err <= 1'b0;
                        busy     <= 1'b1;
                        alu_sel  <= r_mem[0][11:8];
                        alu_data <= r_mem[0][7:0];
                        r_state  <= S_ISSUE;
                    end
                end

                // Y is sampled on the edge that ends the settle window, so the
                // captured value is visible together with step_valid in CAPTURE.
                S_ISSUE: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                        alu_sel  <= IDLE_SEL;
                        alu_data <= '0;
                    end else if (r_settle == '0) begin
                        step_result <= alu_y;
                        step_valid  <= 1'b1;
                        r_state     <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end

                S_CAPTURE: begin
                    alu_sel  <= IDLE_SEL;
                    alu_data <= '0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_pc == r_last) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_GAP;
                    end
                end

                // The idle selector between steps makes repeated opcodes distinct events.
                S_GAP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        alu_sel  <= w_instr[11:8];
                        alu_data <= w_instr[7:0];
                        r_settle <= SETTLE_INIT;
                        r_state  <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    alu_sel  <= IDLE_SEL;
                    alu_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small event-driven ALU model on the selector bus.
module tb_alu_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_we;
    logic [3:0]        prog_addr;
    logic [11:0]       prog_wdata;
    logic              start;
    logic [3:0]        last_addr;
    logic              abort;
    logic [3:0]        alu_sel;
    logic signed [7:0] alu_data;
    logic signed [7:0] alu_y;
    logic              busy;
    logic              done;
    logic              step_valid;
    logic signed [7:0] step_result;
    logic              prog_err;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_sequencer #(.ADDR_W(4), .SETTLE_CYCLES(1), .IDLE_SEL(4'b0000)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .last_addr(last_addr), .abort(abort),
        .alu_sel(alu_sel), .alu_data(alu_data), .alu_y(alu_y), .busy(busy), .done(done),
        .step_valid(step_valid), .step_result(step_result), .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    // ALU model: combinational Y for compute ops, Y held for load/store/swap;
    // A/B mutate only when the selector changes.
    logic signed [7:0] mA, mB, mYh;
    logic [3:0]        mPrev;

    always_comb begin
        case (alu_sel)
            4'h0:    alu_y = mA + mB;
            4'h1:    alu_y = mA - mB;
            4'h2:    alu_y = mA <<< 1;
            4'h3:    alu_y = mA >>> 1;
            4'hC:    alu_y = -mA;
            4'hD, 4'hE, 4'hF: alu_y = mYh;
            default: alu_y = mA + alu_data;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mA <= '0; mB <= '0; mYh <= '0; mPrev <= 4'h0;
        end else begin
            mYh   <= alu_y;
            mPrev <= alu_sel;
            if (alu_sel != mPrev) begin
                case (alu_sel)
                    4'hD: mB <= alu_data;
                    4'hE: begin mA <= mB; mB <= mA; end
                    4'hF: mA <= alu_data;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sv got %b want 0", step_valid); end
        n_cmp++; if (step_result !== 8'sd0) begin n_fail++; $display("FAIL reset_sr got %0d want 0", step_result); end
        n_cmp++; if (alu_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h want 0", alu_sel); end
        n_cmp++; if (alu_data !== 8'sd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", alu_data); end
        n_cmp++; if (prog_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", prog_err); end
    endtask

    task automatic test_basic();
        logic eb, ev, ed;
        logic signed [7:0] esr;
        wr(4'd0, 12'hF05); wr(4'd1, 12'h200); wr(4'd2, 12'hC00);
        last_addr = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            eb = (c <= 8);
            ev = (c == 2 || c == 5 || c == 8);
            ed = (c == 9);
            esr = (c == 2) ? 8'sd0 : (c == 5) ? 8'sd10 : -8'sd5;
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL basic_busy c%0d got %b want %b", c, busy, eb); end
            n_cmp++; if (step_valid !== ev) begin n_fail++; $display("FAIL basic_sv c%0d got %b want %b", c, step_valid, ev); end
            n_cmp++; if (done !== ed) begin n_fail++; $display("FAIL basic_done c%0d got %b want %b", c, done, ed); end
            if (ev) begin
                n_cmp++; if (step_result !== esr) begin n_fail++; $display("FAIL basic_sr c%0d got %0d want %0d", c, step_result, esr); end
            end
            tick();
        end
    endtask

    task automatic test_single_asr();
        wr(4'd0, 12'hFFB); wr(4'd1, 12'h300);
        last_addr = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin
                n_cmp++; if (alu_data !== -8'sd5) begin n_fail++; $display("FAIL asr_data got %0d want -5", alu_data); end
            end
            if (c == 3) begin
                n_cmp++; if (alu_sel !== 4'h0) begin n_fail++; $display("FAIL asr_gap_sel got %h want 0", alu_sel); end
            end
            if (c == 5) begin
                n_cmp++; if (step_result !== -8'sd3) begin n_fail++; $display("FAIL asr_sr got %0d want -3", step_result); end
            end
            if (c == 6) begin
                n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL asr_done got %b want 1", done); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back_swap();
        int ndone = 0;
        wr(4'd0, 12'hF03); wr(4'd1, 12'hD07); wr(4'd2, 12'hE00); wr(4'd3, 12'hE00);
        last_addr = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (done) ndone++;
            if (c == 8) begin
                n_cmp++; if (mA !== 8'sd7 || mB !== 8'sd3) begin n_fail++; $display("FAIL swap1 got A=%0d B=%0d want 7/3", mA, mB); end
            end
            if (c == 9) begin
                n_cmp++; if (alu_sel !== 4'h0) begin n_fail++; $display("FAIL swap_gap_sel got %h want 0", alu_sel); end
            end
            tick();
        end
        n_cmp++; if (mA !== 8'sd3 || mB !== 8'sd7) begin n_fail++; $display("FAIL swap2 got A=%0d B=%0d want 3/7", mA, mB); end
        n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL swap_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_abort();
        logic ev;
        wr(4'd0, 12'hF11); wr(4'd1, 12'h200); wr(4'd2, 12'hC00);
        last_addr = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            ev = (c == 2);
            n_cmp++; if (busy !== (c <= 4)) begin n_fail++; $display("FAIL abort_busy c%0d got %b want %b", c, busy, (c <= 4)); end
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done c%0d got %b want 0", c, done); end
            n_cmp++; if (step_valid !== ev) begin n_fail++; $display("FAIL abort_sv c%0d got %b want %b", c, step_valid, ev); end
            if (c >= 2) begin
                n_cmp++; if (step_result !== 8'sd10) begin n_fail++; $display("FAIL abort_sr c%0d got %0d want 10", c, step_result); end
            end
            if (c >= 5) begin
                n_cmp++; if (alu_sel !== 4'h0) begin n_fail++; $display("FAIL abort_sel c%0d got %h want 0", c, alu_sel); end
            end
            if (c == 4) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic test_prog_err();
        wr(4'd0, 12'hF02); wr(4'd1, 12'h200);
        for (int run = 0; run < 2; run++) begin
            last_addr = 4'd1; start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 7; c++) begin
                if (c == 1) begin
                    n_cmp++; if (prog_err !== 1'b0) begin n_fail++; $display("FAIL perr_clear run%0d got %b want 0", run, prog_err); end
                end
                if (c == 5) begin
                    n_cmp++; if (step_result !== 8'sd4) begin n_fail++; $display("FAIL perr_sr run%0d got %0d want 4", run, step_result); end
                end
                if (c == 7 && run == 0) begin
                    n_cmp++; if (prog_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got %b want 1", prog_err); end
                end
                if (c == 2 && run == 0) begin
                    prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 12'hC00;
                end
                tick();
                prog_we = 1'b0;
            end
        end
    endtask

    task automatic test_full_memory();
        int nsv = 0;
        for (int a = 0; a < 16; a++) wr(4'(a), 12'hF00 | 12'(a));
        last_addr = 4'd15; start = 1'b1;
        tick();
        for (int c = 1; c <= 50; c++) begin
            if (c == 49) start = 1'b0;
            if (step_valid) nsv++;
            n_cmp++; if (busy !== (c <= 47)) begin n_fail++; $display("FAIL full_busy c%0d got %b want %b", c, busy, (c <= 47)); end
            n_cmp++; if (done !== (c == 48)) begin n_fail++; $display("FAIL full_done c%0d got %b want %b", c, done, (c == 48)); end
            tick();
        end
        n_cmp++; if (nsv != 16) begin n_fail++; $display("FAIL full_steps got %0d want 16", nsv); end
    endtask

    task automatic test_reset_mid_capture();
        wr(4'd0, 12'hF09); wr(4'd1, 12'h200);
        last_addr = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sv got %b want 1", step_valid); end
        #2 reset = 1'b1;
        #1;
        test_reset();
        tick();
        reset = 1'b0;
        tick();
        last_addr = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (alu_sel !== 4'hF || alu_data !== 8'sd9) begin n_fail++; $display("FAIL rst_issue got %h/%0d want f/9", alu_sel, alu_data); end
        tick();
        n_cmp++; if (step_valid !== 1'b1 || step_result !== 8'sd0) begin n_fail++; $display("FAIL rst_cap got %b/%0d want 1/0", step_valid, step_result); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_done got %b want 1", done); end
        tick();
        n_cmp++; if (mA !== 8'sd9) begin n_fail++; $display("FAIL rst_exec got A=%0d want 9", mA); end
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; last_addr = '0; abort = 1'b0;
        #3;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        test_basic();
        test_single_asr();
        test_back_to_back_swap();
        test_abort();
        test_prog_err();
        test_full_memory();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
